// File: rtl/count_cmd_gen.sv
// Button front end: 2-flop sync, debounce, press detect, up/down auto-repeat, arbitration, flag gating.
// Pulse leaves DEBOUNCE_CYCLES+3 edges after the first clean sample; no backpressure, commands are fire-and-forget.
module count_cmd_gen #(
    parameter int CNT_W           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             flag_count_max,
    input  logic             flag_count_min,
    output logic             count_inc,
    output logic             count_dec,
    output logic             load_en,
    output logic [CNT_W-1:0] count_to,
    output logic             cmd_blocked
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

    // Bit 0 = up, bit 1 = down, bit 2 = load.
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       deb_q, deb_d, deb_prev_q;
    logic [DBW-1:0]   db_cnt_q [3];
    logic [DBW-1:0]   db_cnt_d [3];

    rpt_state_e       rpt_q [2];
    rpt_state_e       rpt_d [2];
    logic [RW-1:0]    rpt_cnt_q [2];
    logic [RW-1:0]    rpt_cnt_d [2];
    logic [1:0]       rpt_ev;
    logic             ld_ev;

    logic             inc_q, dec_q, load_q, blk_q;
    logic             inc_d, dec_d, load_d, blk_d;
    logic [CNT_W-1:0] count_to_q, count_to_d;

    assign btn_raw = {btn_load, btn_down, btn_up};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            deb_d[i]    = deb_q[i];
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // A debounced release overrides every state so no event escapes on the release cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_d[i]     = rpt_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            rpt_ev[i]    = 1'b0;
            if (!deb_q[i]) begin
                rpt_d[i]     = IDLE;
                rpt_cnt_d[i] = '0;
            end else begin
                case (rpt_q[i])
                    IDLE: begin
                        if (!deb_prev_q[i]) begin
                            rpt_ev[i]    = 1'b1;
                            rpt_d[i]     = HOLD;
                            rpt_cnt_d[i] = '0;
                        end
                    end
                    HOLD: begin
                        if (rpt_cnt_q[i] == RW'(HOLD_CYCLES - 1)) begin
                            rpt_ev[i]    = 1'b1;
                            rpt_d[i]     = REPEAT;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (rpt_cnt_q[i] == RW'(REPEAT_CYCLES - 1)) begin
                            rpt_ev[i]    = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    default: begin
                        rpt_d[i]     = IDLE;
                        rpt_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    assign ld_ev = deb_q[2] & ~deb_prev_q[2];

    always_comb begin
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        load_d     = 1'b0;
        blk_d      = 1'b0;
        count_to_d = count_to_q;
        if (ld_ev) begin
            load_d     = 1'b1;
            count_to_d = load_value;
        end else if (rpt_ev[0] && !rpt_ev[1]) begin
            if (flag_count_max) blk_d = 1'b1;
            else                inc_d = 1'b1;
        end else if (rpt_ev[1] && !rpt_ev[0]) begin
            if (flag_count_min) blk_d = 1'b1;
            else                dec_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                rpt_q[i]     <= IDLE;
                rpt_cnt_q[i] <= '0;
            end
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            load_q     <= 1'b0;
            blk_q      <= 1'b0;
            count_to_q <= '1;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int i = 0; i < 2; i++) begin
                rpt_q[i]     <= rpt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            load_q     <= load_d;
            blk_q      <= blk_d;
            count_to_q <= count_to_d;
        end
    end

    assign count_inc   = inc_q;
    assign count_dec   = dec_q;
    assign load_en     = load_q;
    assign cmd_blocked = blk_q;
    assign count_to    = count_to_q;

endmodule

// File: tb/tb_count_cmd_gen.sv
// Bench for count_cmd_gen: table of press scenarios, directed timing sequences and a random run,
// all shadowed by a per-cycle reference model built from the button rules.
module tb_count_cmd_gen;

    localparam int D    = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
    logic [3:0] load_value = 4'h0;
    logic       fmax = 1'b0, fmin = 1'b0;
    logic       count_inc, count_dec, load_en, cmd_blocked;
    logic [3:0] count_to;

    int n_cmp = 0;
    int n_bad = 0;

    count_cmd_gen #(
        .CNT_W(4), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .load_value(load_value),
        .flag_count_max(fmax), .flag_count_min(fmin),
        .count_inc(count_inc), .count_dec(count_dec), .load_en(load_en),
        .count_to(count_to), .cmd_blocked(cmd_blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples age two edges, a run of D disagreeing samples flips
    // the debounced level, and events come from the age of the current press.
    bit         m_rq1 [3];
    bit         m_rq2 [3];
    bit         m_deb [3];
    int         m_run [3];
    int         m_age [3];
    bit         m_ev  [3];
    bit         m_raw [3];
    bit         e_inc, e_dec, e_load, e_blk;
    logic [3:0] e_cto = 4'hF;
    int         t_inc, t_dec, t_load, t_blk;

    initial begin : model
        forever begin
            @(negedge clk);
            m_raw[0] = btn_up;
            m_raw[1] = btn_down;
            m_raw[2] = btn_load;
            if (reset) begin
                for (int b = 0; b < 3; b++) begin
                    m_rq1[b] = 0; m_rq2[b] = 0; m_deb[b] = 0; m_run[b] = 0; m_age[b] = -1;
                end
                e_inc = 0; e_dec = 0; e_load = 0; e_blk = 0; e_cto = 4'hF;
            end else begin
                for (int b = 0; b < 2; b++)
                    m_ev[b] = m_deb[b] && (m_age[b] == 0 ||
                              (m_age[b] >= HOLD && (m_age[b] - HOLD) % REP == 0));
                m_ev[2] = m_deb[2] && m_age[2] == 0;
                e_inc = 0; e_dec = 0; e_load = 0; e_blk = 0;
                if (m_ev[2]) begin
                    e_load = 1;
                    e_cto  = load_value;
                end else if (m_ev[0] && !m_ev[1]) begin
                    if (fmax) e_blk = 1; else e_inc = 1;
                end else if (m_ev[1] && !m_ev[0]) begin
                    if (fmin) e_blk = 1; else e_dec = 1;
                end
                for (int b = 0; b < 3; b++) begin
                    bit s;
                    bit was;
                    s   = m_rq2[b];
                    was = m_deb[b];
                    m_rq2[b] = m_rq1[b];
                    m_rq1[b] = m_raw[b];
                    if (s != m_deb[b]) begin
                        m_run[b]++;
                        if (m_run[b] == D) begin
                            m_deb[b] = s;
                            m_run[b] = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                    if (m_deb[b] && !was) m_age[b] = 0;
                    else if (m_deb[b])    m_age[b]++;
                    else                  m_age[b] = -1;
                end
            end
            check("model_inc", int'(count_inc), int'(e_inc));
            check("model_dec", int'(count_dec), int'(e_dec));
            check("model_load", int'(load_en), int'(e_load));
            check("model_blk", int'(cmd_blocked), int'(e_blk));
            check("model_count_to", int'(count_to), int'(e_cto));
            check("one_hot", int'((int'(count_inc) + int'(count_dec) + int'(load_en)) <= 1), 1);
            if (!reset) begin
                t_inc  += int'(count_inc);
                t_dec  += int'(count_dec);
                t_load += int'(load_en);
                t_blk  += int'(cmd_blocked);
            end
        end
    end

    typedef struct {
        bit         up, dn, ld, fmx, fmn;
        int         hold;
        logic [3:0] lv;
        int         x_inc, x_dec, x_ld, x_blk;
        logic [3:0] x_cto;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        fmax = v.fmx; fmin = v.fmn; load_value = v.lv;
        t_inc = 0; t_dec = 0; t_load = 0; t_blk = 0;
        btn_up = v.up; btn_down = v.dn; btn_load = v.ld;
        for (int i = 1; i <= v.hold; i++) begin
            tick();
            if (i == v.hold) begin
                btn_up = 0; btn_down = 0; btn_load = 0;
            end
        end
        repeat (30) tick();
        check({nm, "_inc"}, t_inc, v.x_inc);
        check({nm, "_dec"}, t_dec, v.x_dec);
        check({nm, "_load"}, t_load, v.x_ld);
        check({nm, "_blk"}, t_blk, v.x_blk);
        check({nm, "_count_to"}, int'(count_to), int'(v.x_cto));
        fmax = 0; fmin = 0;
    endtask

    int pos_q [$];
    int exp_up [5] = '{7, 23, 31, 39, 47};
    int tmr [3];

    initial begin : main
        //            up    dn    ld    fmx   fmn   hold lv     inc dec ld blk cto
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 4'h0,  1, 0, 0, 0, 4'hF};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 41, 4'h0,  5, 0, 0, 0, 4'hF};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30, 4'h0,  0, 3, 0, 0, 4'hF};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  3, 4'h0,  0, 0, 0, 0, 4'hF};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  4, 4'h0,  0, 1, 0, 0, 4'hF};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 50, 4'h5,  0, 0, 1, 0, 4'h5};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10, 4'h0,  0, 0, 0, 1, 4'h5};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, 4'h0,  0, 0, 0, 1, 4'h5};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 4'h0,  0, 0, 0, 0, 4'h5};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10, 4'h9,  0, 0, 1, 0, 4'h9};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20, 4'h0,  0, 0, 0, 0, 4'h9};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17, 4'h0,  2, 0, 0, 0, 4'h9};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20, 4'h3,  1, 0, 1, 0, 4'h3};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 25, 4'h0,  0, 0, 0, 3, 4'h3};

        repeat (3) @(negedge clk);
        check("rst_count_to", int'(count_to), 15);
        check("rst_outputs", int'({count_inc, count_dec, load_en, cmd_blocked}), 0);
        #1 reset = 0;
        repeat (3) tick();

        // Held up button: first pulse, hold delay, repeat period, clean stop on release.
        btn_up = 1;
        pos_q.delete();
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (count_inc) pos_q.push_back(k);
            #1;
            if (k == 45) btn_up = 0;
        end
        check("up_npulse", pos_q.size(), 5);
        for (int i = 0; i < pos_q.size() && i < 5; i++) check("up_pulse_pos", pos_q[i], exp_up[i]);

        // Bouncing down button: 2 high, 1 low, then a stable stretch.
        btn_down = 1;
        pos_q.delete();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (count_dec) pos_q.push_back(k);
            #1;
            btn_down = (k < 2) || (k >= 3 && k < 15);
        end
        check("bounce_npulse", pos_q.size(), 1);
        if (pos_q.size() > 0) check("bounce_pulse_pos", pos_q[0], 10);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        // Reset in the middle of auto-repeat with the button still held.
        btn_up = 1;
        repeat (30) tick();
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_outputs", int'({count_inc, count_dec, load_en, cmd_blocked}), 0);
            check("midrst_count_to", int'(count_to), 15);
            #1;
        end
        reset = 0;
        pos_q.delete();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (count_inc) pos_q.push_back(k);
            #1;
        end
        check("postrst_npulse", pos_q.size(), 1);
        if (pos_q.size() > 0) check("postrst_pulse_pos", pos_q[0], 7);
        btn_up = 0;
        repeat (30) tick();

        // Random buttons, flags, load values and rare resets against the model.
        for (int b = 0; b < 3; b++) tmr[b] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int b = 0; b < 3; b++) begin
                tmr[b]--;
                if (tmr[b] <= 0) begin
                    tmr[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 50);
                    case (b)
                        0: btn_up = ~btn_up;
                        1: btn_down = ~btn_down;
                        default: begin
                            btn_load   = ~btn_load;
                            load_value = 4'($urandom_range(0, 15));
                        end
                    endcase
                end
            end
            fmax  = ($urandom_range(0, 3) == 0);
            fmin  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 799) == 0);
        end
        reset = 0; btn_up = 0; btn_down = 0; btn_load = 0;
        repeat (30) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
